// File: rtl/parking_access_scheduler.sv
// Smart-parking access scheduler: arbitrates entry/exit, manages an 8-slot map and parked time.
// Optional fee output is enabled by defining PARK_FEE_EN.
module parking_access_scheduler #(
    parameter int         TIME_W   = 8,
    parameter logic [7:0] INIT_OCC = 8'h00,
    parameter int         FEE_RATE = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [2:0]        pattern,
    input  logic              entry_req,
    input  logic              exit_req,
    input  logic [2:0]        exit_token,
    output logic              entry_ack,
    output logic              entry_reject,
    output logic [2:0]        entry_token,
    output logic              exit_ack,
    output logic              exit_reject,
    output logic [TIME_W-1:0] time_total,
    output logic [7:0]        occupancy,
    output logic [3:0]        parked,
    output logic [3:0]        empty
`ifdef PARK_FEE_EN
    ,
    output logic [15:0]       fee
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic              pend_entry;
    logic              pend_exit;
    logic [2:0]        token_q;
    logic              sel_exit;
    logic              last_exit;
    logic [TIME_W-1:0] now;
    logic [TIME_W-1:0] stamp [8];

    logic              pick_exit;
    logic              clr_entry;
    logic              clr_exit;
    logic              full;
    logic [2:0]        free_slot;
    logic [2:0]        exit_slot;
    logic              exit_hit;
    logic [7:0]        occ_set;
    logic [7:0]        occ_clr;
    logic [TIME_W-1:0] diff;

    function automatic logic [2:0] low_free(input logic [7:0] m);
        low_free = '0;
        for (int i = 7; i >= 0; i--) begin
            if (!m[i]) low_free = 3'(i);
        end
    endfunction

    function automatic logic [3:0] pop8(input logic [7:0] m);
        pop8 = '0;
        for (int i = 0; i < 8; i++) begin
            pop8 = pop8 + {3'b000, m[i]};
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pend_entry || pend_exit) state_next = SERVE;
            SERVE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Exit wins a tie unless it was the last one served.
    assign pick_exit = pend_exit && (!pend_entry || !last_exit);
    assign clr_entry = (state == RESP) && !sel_exit;
    assign clr_exit  = (state == RESP) && sel_exit;

    assign full      = &occupancy;
    assign free_slot = low_free(occupancy);
    assign exit_slot = token_q ^ pattern;
    assign exit_hit  = occupancy[exit_slot];
    assign occ_set   = occupancy | (8'h01 << free_slot);
    assign occ_clr   = occupancy & ~(8'h01 << exit_slot);
    assign diff      = now - stamp[exit_slot];

`ifdef PARK_FEE_EN
    logic [TIME_W+15:0] prod;
    logic [15:0]        fee_sat;
    assign prod    = {16'b0, diff} * (TIME_W+16)'(FEE_RATE);
    assign fee_sat = (|prod[TIME_W+15:16]) ? 16'hFFFF : prod[15:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_entry   <= 1'b0;
            pend_exit    <= 1'b0;
            token_q      <= '0;
            sel_exit     <= 1'b0;
            last_exit    <= 1'b0;
            now          <= '0;
            for (int i = 0; i < 8; i++) stamp[i] <= '0;
            entry_ack    <= 1'b0;
            entry_reject <= 1'b0;
            exit_ack     <= 1'b0;
            exit_reject  <= 1'b0;
            entry_token  <= '0;
            time_total   <= '0;
            occupancy    <= INIT_OCC;
            parked       <= pop8(INIT_OCC);
            empty        <= 4'd8 - pop8(INIT_OCC);
`ifdef PARK_FEE_EN
            fee          <= '0;
`endif
        end else begin
            if (tick) now <= now + 1'b1;

            // A new pulse survives the cycle its predecessor is retired.
            pend_entry <= (pend_entry && !clr_entry) || entry_req;
            pend_exit  <= (pend_exit && !clr_exit) || exit_req;
            if (exit_req && (!pend_exit || clr_exit)) token_q <= exit_token;

            if (state == IDLE && (pend_entry || pend_exit)) sel_exit <= pick_exit;

            entry_ack    <= 1'b0;
            entry_reject <= 1'b0;
            exit_ack     <= 1'b0;
            exit_reject  <= 1'b0;

            if (state == SERVE) begin
                if (!sel_exit) begin
                    if (full) begin
                        entry_reject <= 1'b1;
                    end else begin
                        entry_ack         <= 1'b1;
                        occupancy         <= occ_set;
                        parked            <= pop8(occ_set);
                        empty             <= 4'd8 - pop8(occ_set);
                        stamp[free_slot]  <= now;
                        entry_token       <= free_slot ^ pattern;
                    end
                end else begin
                    if (!exit_hit) begin
                        exit_reject <= 1'b1;
                    end else begin
                        exit_ack   <= 1'b1;
                        occupancy  <= occ_clr;
                        parked     <= pop8(occ_clr);
                        empty      <= 4'd8 - pop8(occ_clr);
                        time_total <= diff;
`ifdef PARK_FEE_EN
                        fee        <= fee_sat;
`endif
                    end
                end
            end

            if (state == RESP) last_exit <= sel_exit;
        end
    end

endmodule

// File: tb/tb_parking_access_scheduler.sv
// Scoreboard bench for parking_access_scheduler: model predicts each response pulse.
module tb_parking_access_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] pattern = 3'b101;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [2:0] exit_token = '0;
    logic       entry_ack;
    logic       entry_reject;
    logic [2:0] entry_token;
    logic       exit_ack;
    logic       exit_reject;
    logic [7:0] time_total;
    logic [7:0] occupancy;
    logic [3:0] parked;
    logic [3:0] empty;
`ifdef PARK_FEE_EN
    logic [15:0] fee;
`endif

    parking_access_scheduler #(
        .TIME_W(8),
        .INIT_OCC(8'h00),
        .FEE_RATE(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick(tick),
        .pattern(pattern),
        .entry_req(entry_req),
        .exit_req(exit_req),
        .exit_token(exit_token),
        .entry_ack(entry_ack),
        .entry_reject(entry_reject),
        .entry_token(entry_token),
        .exit_ack(exit_ack),
        .exit_reject(exit_reject),
        .time_total(time_total),
        .occupancy(occupancy),
        .parked(parked),
        .empty(empty)
`ifdef PARK_FEE_EN
        ,
        .fee(fee)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [2:0] tok;
        logic [7:0] tt;
        logic [7:0] occ;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass = 0;

    logic [7:0] mocc;
    logic [7:0] mstamp [8];
    logic [7:0] mnow;
    logic [2:0] mtok;
    logic [7:0] mtt;
    logic       mlast_exit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mocc = 8'h00;
        for (int i = 0; i < 8; i++) mstamp[i] = '0;
        mnow = '0;
        mtok = '0;
        mtt = '0;
        mlast_exit = 1'b0;
        q.delete();
    endtask

    task automatic push(input int kind);
        exp_t e;
        e.kind = kind;
        e.tok = mtok;
        e.tt = mtt;
        e.occ = mocc;
        q.push_back(e);
    endtask

    task automatic model_entry();
        int s;
        mlast_exit = 1'b0;
        if (mocc == 8'hFF) begin
            push(1);
        end else begin
            s = 0;
            while (mocc[s]) s++;
            mocc[s] = 1'b1;
            mstamp[s] = mnow;
            mtok = 3'(s) ^ pattern;
            push(0);
        end
    endtask

    task automatic model_exit(input logic [2:0] tok);
        logic [2:0] s;
        mlast_exit = 1'b1;
        s = tok ^ pattern;
        if (!mocc[s]) begin
            push(3);
        end else begin
            mocc[s] = 1'b0;
            mtt = mnow - mstamp[s];
            push(2);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] p;
        int kind;
        exp_t e;
        p = {exit_reject, exit_ack, entry_reject, entry_ack};
        if (p != 4'b0) begin
            kind = entry_ack ? 0 : entry_reject ? 1 : exit_ack ? 2 : 3;
            check("onehot", $countones(p), 1);
            if (q.size() == 0) begin
                check("unexpected_pulse", p, 0);
            end else begin
                e = q.pop_front();
                check("kind", kind, e.kind);
                check("entry_token", entry_token, e.tok);
                check("time_total", time_total, e.tt);
                check("occupancy", occupancy, e.occ);
                check("parked", parked, $countones(e.occ));
                check("empty", empty, 8 - $countones(e.occ));
`ifdef PARK_FEE_EN
                check("fee", fee, e.tt * 5);
`endif
            end
        end
    end

    task automatic pulse(input logic e, input logic x, input logic [2:0] tok);
        @(posedge clk);
        #1;
        entry_req = e;
        exit_req = x;
        exit_token = tok;
        @(posedge clk);
        #1;
        entry_req = 1'b0;
        exit_req = 1'b0;
    endtask

    task automatic wait_done();
        int cnt = 0;
        while (q.size() != 0 && cnt < 30) begin
            @(posedge clk);
            cnt++;
        end
        if (q.size() != 0) begin
            check("timeout", q.size(), 0);
            q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic advance(input int n);
        @(posedge clk);
        #1;
        tick = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        tick = 1'b0;
        mnow = mnow + 8'(n);
    endtask

    task automatic do_entry();
        model_entry();
        pulse(1'b1, 1'b0, 3'b000);
        wait_done();
    endtask

    task automatic do_exit(input logic [2:0] tok);
        model_exit(tok);
        pulse(1'b0, 1'b1, tok);
        wait_done();
    endtask

    task automatic do_tie(input logic [2:0] tok);
        if (!mlast_exit) begin
            model_exit(tok);
            model_entry();
        end else begin
            model_entry();
            model_exit(tok);
        end
        pulse(1'b1, 1'b1, tok);
        wait_done();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        entry_req = 1'b0;
        exit_req = 1'b0;
        tick = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state();
        check("rst_occ", occupancy, 8'h00);
        check("rst_parked", parked, 0);
        check("rst_empty", empty, 8);
        check("rst_token", entry_token, 0);
        check("rst_time", time_total, 0);
    endtask

    initial begin
        model_reset();
        apply_reset();
        check_reset_state();

        // T1 + T2: fill all slots, then one reject
        for (int i = 0; i < 8; i++) do_entry();
        check("full_occ", occupancy, 8'hFF);
        do_entry();
        check("reject_occ", occupancy, 8'hFF);

        for (int i = 0; i < 8; i++) do_exit(3'(i) ^ pattern);
        check("drained_occ", occupancy, 8'h00);

        // T3: 25 ticks parked starting at now=10
        advance(10);
        do_entry();
        advance(25);
        do_exit(3'b000 ^ pattern);

        // T4: stay crosses the time-base wrap, then a stale token
        advance(250 - 35);
        do_entry();
        advance(10);
        do_exit(3'b000 ^ pattern);
        do_exit(3'b011 ^ pattern);

        // T5: simultaneous requests alternate priority
        apply_reset();
        check_reset_state();
        do_tie(3'b000 ^ pattern);
        do_exit(3'b000 ^ pattern);
        do_tie(3'b000 ^ pattern);
        do_entry();
        do_entry();

        // T6: reset while serving an entry
        pulse(1'b1, 1'b0, 3'b000);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t6_occ", occupancy, 8'h00);
        check("t6_parked", parked, 0);
        check("t6_empty", empty, 8);
        do_entry();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
